// File: rtl/sseg_tdm_scan.sv
// Time-multiplexed seven-segment scanner: N_DIGITS hex digits with decimal points,
// leading-zero blanking, floating minus sign, PWM brightness and per-frame input snapshot.
module sseg_tdm_scan #(
    parameter int N_DIGITS      = 4,
    parameter int SCAN_DIV_LOG2 = 15,
    parameter int BRIGHT_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  sign,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [DW-1:0] LAST = DW'(N_DIGITS - 1);

    logic [SCAN_DIV_LOG2-1:0] pres_q, pres_d;
    logic [DW-1:0]            dig_q, dig_d;
    logic                     tick, snap;

    logic [4*N_DIGITS-1:0]    data_q;
    logic [N_DIGITS-1:0]      dps_q;
    logic                     sign_q, blz_q;
    logic [BRIGHT_W-1:0]      bright_q;

    logic [6:0]               seg_q, seg_d;
    logic                     dpo_q, dpo_d;
    logic [N_DIGITS-1:0]      an_q, an_d;

    logic [DW-1:0]            msd, minus_pos;
    logic [3:0]               nib;
    logic [6:0]               glyph;
    logic                     blank, lit, on, dp_sel;

    always_comb begin
        tick   = en & (&pres_q);
        snap   = tick & (dig_q == LAST);
        pres_d = en ? pres_q + SCAN_DIV_LOG2'(1) : pres_q;
        dig_d  = dig_q;
        // explicit wrap keeps non-power-of-two digit counts in range
        if (tick) begin
            dig_d = (dig_q == LAST) ? '0 : dig_q + DW'(1);
        end
    end

    always_comb begin
        msd    = '0;
        nib    = '0;
        dp_sel = 1'b0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (data_q[4*k +: 4] != 4'h0) msd = DW'(k);
            if (dig_q == DW'(k)) begin
                nib    = data_q[4*k +: 4];
                dp_sel = dps_q[k];
            end
        end

        minus_pos = LAST;
        if (blz_q && (msd != LAST)) minus_pos = msd + DW'(1);
        blank = blz_q && (dig_q > msd);

        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase

        if (sign_q && (dig_q == minus_pos)) seg_d = 7'b0111111;
        else if (blank)                     seg_d = 7'h7F;
        else                                seg_d = glyph;

        // the upper prescaler bits form the PWM ramp within each slot
        lit = (&bright_q) | (pres_q[SCAN_DIV_LOG2-1 -: BRIGHT_W] < bright_q);
        on  = en & lit;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            an_d[k] = ~(on & (dig_q == DW'(k)));
        end
        dpo_d = ~(dp_sel & on);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pres_q   <= '0;
            dig_q    <= '0;
            data_q   <= '0;
            dps_q    <= '0;
            sign_q   <= 1'b0;
            blz_q    <= 1'b0;
            bright_q <= '0;
            seg_q    <= 7'h7F;
            dpo_q    <= 1'b1;
            an_q     <= '1;
        end else begin
            pres_q <= pres_d;
            dig_q  <= dig_d;
            if (snap) begin
                data_q   <= data;
                dps_q    <= dp_in;
                sign_q   <= sign;
                blz_q    <= blank_lz;
                bright_q <= bright;
            end
            seg_q <= seg_d;
            dpo_q <= dpo_d;
            an_q  <= an_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dpo_q;
    assign an          = an_q;
    assign frame_start = snap;

endmodule

// File: tb/tb_sseg_tdm_scan.sv
// Bench for sseg_tdm_scan: directed steps plus randomized inputs checked each cycle
// against a model derived from an enabled-clock count and a frame-snapshot record.
module tb_sseg_tdm_scan;
    localparam int N   = 4;
    localparam int SDL = 4;
    localparam int BW  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic        sign = 1'b0;
    logic        blank_lz = 1'b0;
    logic [1:0]  bright = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    sseg_tdm_scan #(.N_DIGITS(N), .SCAN_DIV_LOG2(SDL), .BRIGHT_W(BW)) u_dut (
        .clock(clock), .reset(reset), .en(en), .data(data), .dp_in(dp_in),
        .sign(sign), .blank_lz(blank_lz), .bright(bright),
        .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // model: E counts enabled clocks since reset; slot = E/16, position in slot = E%16
    int          E;
    logic [15:0] s_data;
    logic [3:0]  s_dp;
    logic        s_sign, s_blz;
    logic [1:0]  s_bright;

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [6:0] glyph(int k);
        int nibs [N];
        int msd, mpos;
        for (int i = 0; i < N; i++) nibs[i] = int'((s_data >> (4*i)) & 16'hF);
        msd = 0;
        for (int i = N-1; i >= 0; i--) begin
            if (nibs[i] != 0) begin msd = i; break; end
        end
        if (s_sign) begin
            mpos = s_blz ? ((msd + 1 > N-1) ? N-1 : msd + 1) : N-1;
            if (k == mpos) return 7'b0111111;
        end
        if (s_blz && k > msd) return 7'h7F;
        return HEX[nibs[k]];
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (E=%0d)", tag, obs, exp, E);
        end
    endtask

    task automatic model_reset();
        E = 0; s_data = '0; s_dp = '0; s_sign = 1'b0; s_blz = 1'b0; s_bright = '0;
    endtask

    task automatic check_dark();
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_seg", {9'h0, seg}, 16'h007F);
        check("rst_dp", {15'h0, dp}, 16'h0001);
        check("rst_fs", {15'h0, frame_start}, 16'h0000);
    endtask

    task automatic step();
        logic [6:0] es;
        logic       ed;
        logic [3:0] ea;
        int         pres, dig;
        bit         lit;
        @(negedge clock);
        check("frame_start", {15'h0, frame_start}, {15'h0, (en && (E % 64 == 63))});
        pres = E % 16;
        dig  = (E / 16) % 4;
        lit  = (s_bright == 2'd3) || ((pres / 4) < int'(s_bright));
        es   = glyph(dig);
        ea   = (en && lit) ? 4'(~(1 << dig)) : 4'hF;
        ed   = !(s_dp[dig] && en && lit);
        @(posedge clock);
        if (en && (E % 64 == 63)) begin
            s_data = data; s_dp = dp_in; s_sign = sign; s_blz = blank_lz; s_bright = bright;
        end
        if (en) E++;
        #1;
        check("seg", {9'h0, seg}, {9'h0, es});
        check("dp", {15'h0, dp}, {15'h0, ed});
        check("an", {12'h0, an}, {12'h0, ea});
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    initial begin
        model_reset();
        repeat (3) begin
            @(posedge clock);
            #1;
            check_dark();
        end
        reset = 1'b1;
        run(20);

        en = 1'b1; data = 16'h1234; bright = 2'd3;
        run(200);
        data = 16'hABCD;
        run(100);

        blank_lz = 1'b1; sign = 1'b1; data = 16'h0005;
        run(130);
        data = 16'h8000;
        run(130);
        data = 16'h0000;
        run(130);

        bright = 2'd1; data = 16'h4321; sign = 1'b0; blank_lz = 1'b0;
        run(130);
        bright = 2'd0; dp_in = 4'b0100;
        run(130);
        bright = 2'd3;
        run(130);

        for (int g = 0; g < 200; g++) begin
            if ((E / 16) % 4 == 2 && E % 16 == 5) break;
            step();
        end
        check("at_dig2", ((E / 16) % 4 == 2) ? 16'd1 : 16'd0, 16'd1);
        en = 1'b0;
        run(20);
        en = 1'b1;
        run(60);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) data = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 31) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) sign = 1'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 63) == 0) bright = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 19) != 0);
            step();
        end

        en = 1'b1; bright = 2'd3;
        run(37);
        #2 reset = 1'b0;
        #1 check_dark();
        model_reset();
        @(posedge clock);
        #1 check_dark();
        #2 reset = 1'b1;
        run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
